// File: rtl/booth_seq_mul_pkg.sv
// ---------------------------------------------------------------------------
// booth_seq_mul_pkg
//   Shared definitions for the sequential radix-2 Booth multiplier:
//     state_e   - controller states (IDLE, RUN, DONE)
//     op_e      - Booth recoding operation for one iteration (NOP, ADD, SUB)
//     booth_op  - maps the {Q[0], q_1} bit pair onto an op_e
// ---------------------------------------------------------------------------
package booth_seq_mul_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } op_e;

    // Radix-2 Booth recoding: 01 ends a run of ones (add M),
    // 10 starts a run of ones (subtract M), 00/11 are inside a run.
    function automatic op_e booth_op(input logic [1:0] pair);
        case (pair)
            2'b01:   return OP_ADD;
            2'b10:   return OP_SUB;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_seq_mul_adder.sv
// ---------------------------------------------------------------------------
// NBitAdder
//   Plain W-bit ripple/behavioural adder with carry in and carry out.
//   Ports:
//     a_i, b_i  - W-bit addends
//     cin_i     - carry in (used as the +1 of a two's-complement subtract)
//     sum_o     - W-bit sum
//     cout_o    - carry out of the top bit
// ---------------------------------------------------------------------------
module NBitAdder #(
    parameter int W = 6
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};

endmodule

// File: rtl/booth_seq_mul.sv
// ---------------------------------------------------------------------------
// booth_seq_mul
//   Sequential radix-2 Booth multiplier for N-bit signed operands. One Booth
//   iteration (add/sub/nop followed by an arithmetic right shift of
//   {A,Q,q_1}) is performed per clock, so a multiply takes N RUN cycles plus
//   one DONE cycle.
//   Ports:
//     clk           - clock, all state changes on the rising edge
//     rst           - synchronous active-high reset, aborts any operation
//     start         - request a multiply; only looked at in IDLE
//     multiplicand  - signed M, captured on the accepting edge
//     multiplier    - signed Q, captured on the accepting edge
//     busy          - high whenever the controller is not IDLE
//     done          - one-cycle pulse while in DONE
//     product       - registered signed 2N-bit M*Q, held until the next DONE
// ---------------------------------------------------------------------------
module booth_seq_mul
    import booth_seq_mul_pkg::*;
#(
    parameter int N = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = ($clog2(N) < 1) ? 1 : $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_e         state_q, state_d;
    logic [N:0]     a_q, a_d;        // accumulator, one guard bit so -M never overflows
    logic [N:0]     m_q, m_d;        // sign-extended multiplicand
    logic [N-1:0]   q_q, q_d;        // multiplier, shifted out LSB first
    logic           q1_q, q1_d;      // Booth history bit
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] prod_q, prod_d;

    op_e            op;
    logic [N:0]     add_b;
    logic           add_cin;
    logic [N:0]     sum;
    logic           unused_cout;
    logic [N:0]     a_sh;
    logic [N-1:0]   q_sh;
    logic           q1_sh;

    // ---------------- datapath ----------------
    always_comb op = booth_op({q_q[0], q1_q});

    // Subtraction reuses the adder as A + ~M + 1.
    always_comb begin
        add_b   = '0;
        add_cin = 1'b0;
        case (op)
            OP_ADD: add_b = m_q;
            OP_SUB: begin
                add_b   = ~m_q;
                add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    NBitAdder #(.W(N + 1)) u_add (
        .a_i    (a_q),
        .b_i    (add_b),
        .cin_i  (add_cin),
        .sum_o  (sum),
        .cout_o (unused_cout)
    );

    // Arithmetic right shift of {sum, Q, q_1} by one.
    assign a_sh  = {sum[N], sum[N:1]};
    assign q_sh  = {sum[0], q_q[N-1:1]};
    assign q1_sh = q_q[0];

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        m_d     = m_q;
        q_d     = q_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_d     = '0;
                    q_d     = multiplier;
                    q1_d    = 1'b0;
                    m_d     = {multiplicand[N-1], multiplicand};
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                a_d   = a_sh;
                q_d   = q_sh;
                q1_d  = q1_sh;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    // The full product fits in 2N bits; A's guard bit is
                    // only a copy of the sign at this point.
                    prod_d  = {a_sh[N-1:0], q_sh};
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            m_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            m_q     <= m_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign product = prod_q;

endmodule

// File: tb/tb_booth_seq_mul.sv
// ---------------------------------------------------------------------------
// tb_booth_seq_mul
//   Self-checking bench for booth_seq_mul (N=5). Expected products come from
//   plain signed multiplication of the operands; timing expectations come from
//   the documented latency (done seen N+1 edges after the accepting edge
//   counted as the first).
// ---------------------------------------------------------------------------
module tb_booth_seq_mul;

    localparam int N = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   mc;
    logic [N-1:0]   mp;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    int n_chk  = 0;
    int n_fail = 0;
    logic [2*N-1:0] last_prod;

    booth_seq_mul #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (mc),
        .multiplier   (mp),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] m, input logic [N-1:0] q);
        logic signed [2*N-1:0] sm, sq, r;
        sm = {{N{m[N-1]}}, m};
        sq = {{N{q[N-1]}}, q};
        r  = sm * sq;
        return r;
    endfunction

    // Drives one start pulse and waits (bounded) for done.
    // lat = number of sampled edges up to and including the one after which
    // done is first seen (accepting edge counts as 1); nb = busy samples.
    task automatic do_mul(input logic [N-1:0] m, input logic [N-1:0] q,
                          output int lat, output int nb, output logic [2*N-1:0] p);
        mc = m; mp = q; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        nb  = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy === 1'b1) nb++;
        end
        p = product;
    endtask

    task automatic test_reset;
        int lat, nb;
        logic [2*N-1:0] p;
        // start held together with rst: reset must win
        rst = 1'b1; start = 1'b1; mc = 5'd3; mp = 5'd3;
        @(posedge clk); #1;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_chk++; if (product !== '0) begin n_fail++; $display("FAIL reset_product: got %h expected 000", product); end
        rst = 1'b0; start = 1'b0;
        // first edge after reset release must accept start: M=3, Q=-2
        do_mul(5'd3, 5'h1E, lat, nb, p);
        n_chk++; if (lat != N + 1) begin n_fail++; $display("FAIL reset_first_latency: got %0d expected %0d", lat, N + 1); end
        n_chk++; if (p !== 10'h3FA) begin n_fail++; $display("FAIL m3_qm2_product: got %h expected 3fa", p); end
        n_chk++; if (nb != N + 1) begin n_fail++; $display("FAIL m3_qm2_busy_cycles: got %0d expected %0d", nb, N + 1); end
        last_prod = 10'h3FA;
    endtask

    task automatic test_directed;
        int lat, nb;
        logic [2*N-1:0] p;
        @(posedge clk); #1;
        do_mul(5'h10, 5'h10, lat, nb, p);   // -16 * -16
        n_chk++; if (p !== 10'h100) begin n_fail++; $display("FAIL m16_q16_product: got %h expected 100", p); end
        n_chk++; if (lat != N + 1) begin n_fail++; $display("FAIL m16_q16_latency: got %0d expected %0d", lat, N + 1); end
        @(posedge clk); #1;
        do_mul(5'h10, 5'd7, lat, nb, p);    // -16 * 7
        n_chk++; if (p !== 10'h390) begin n_fail++; $display("FAIL m16_q7_product: got %h expected 390", p); end
        last_prod = 10'h390;
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_start;
        int ndone;
        logic [2*N-1:0] got;
        logic [2*N-1:0] exp_p;
        exp_p = ref_mul(5'd7, 5'h1D);       // 7 * -3
        mc = 5'd7; mp = 5'h1D; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        n_chk++; if (product !== last_prod) begin n_fail++; $display("FAIL hold_product_during_run: got %h expected %h", product, last_prod); end
        // retrigger with different operands, then wiggle inputs
        mc = 5'h10; mp = 5'h10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mc = 5'd1; mp = 5'd1;
        ndone = 0; got = '0;
        for (int i = 0; i < 3 * N; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin ndone++; got = product; end
        end
        n_chk++; if (ndone != 1) begin n_fail++; $display("FAIL ignore_start_done_count: got %0d expected 1", ndone); end
        n_chk++; if (got !== exp_p) begin n_fail++; $display("FAIL ignore_start_product: got %h expected %h", got, exp_p); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_start_idle_after: got %b expected 0", busy); end
        last_prod = exp_p;
    endtask

    task automatic test_back_to_back;
        int lat, nb;
        logic [2*N-1:0] p;
        do_mul(5'd15, 5'd15, lat, nb, p);
        n_chk++; if (p !== 10'h0E1) begin n_fail++; $display("FAIL m15_q15_product: got %h expected 0e1", p); end
        @(posedge clk); #1;                 // IDLE cycle right after DONE
        n_chk++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap: got busy=%b done=%b expected 0 0", busy, done); end
        do_mul(5'd0, 5'h19, lat, nb, p);    // 0 * -7
        n_chk++; if (p !== 10'h000) begin n_fail++; $display("FAIL b2b_product: got %h expected 000", p); end
        n_chk++; if (lat != N + 1) begin n_fail++; $display("FAIL b2b_latency: got %0d expected %0d", lat, N + 1); end
        last_prod = 10'h000;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort;
        int lat, nb, ndone;
        logic [2*N-1:0] p;
        do_mul(5'd5, 5'd5, lat, nb, p);
        n_chk++; if (p !== ref_mul(5'd5, 5'd5)) begin n_fail++; $display("FAIL abort_pre_product: got %h expected %h", p, ref_mul(5'd5, 5'd5)); end
        @(posedge clk); #1;
        mc = 5'h17; mp = 5'd11; start = 1'b1;
        @(posedge clk); #1;                 // RUN cycle 1
        start = 1'b0;
        @(posedge clk); #1;                 // RUN cycle 2
        @(posedge clk); #1;                 // RUN cycle 3
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b expected 0", done); end
        n_chk++; if (product !== '0) begin n_fail++; $display("FAIL abort_product: got %h expected 000", product); end
        ndone = 0;
        for (int i = 0; i < 3 * N; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        n_chk++; if (ndone != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d expected 0", ndone); end
        last_prod = '0;
    endtask

    task automatic test_random;
        int lat, nb, gap;
        logic [2*N-1:0] p;
        logic [N-1:0] m, q;
        for (int k = 0; k < 30; k++) begin
            m = N'($urandom);
            q = N'($urandom);
            if (k == 0) begin m = 5'h10; q = 5'h0F; end
            if (k == 1) begin m = 5'h0F; q = 5'h10; end
            if (k == 2) begin m = 5'h1F; q = 5'h1F; end
            do_mul(m, q, lat, nb, p);
            n_chk++; if (p !== ref_mul(m, q)) begin n_fail++; $display("FAIL rand_product[%0d] m=%h q=%h: got %h expected %h", k, m, q, p, ref_mul(m, q)); end
            n_chk++; if (lat != N + 1) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", k, lat, N + 1); end
            gap = $urandom_range(1, 3);
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mc = '0; mp = '0;
        last_prod = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        test_directed;
        test_ignore_start;
        test_back_to_back;
        test_reset_abort;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_seq_mul.md
BOOTH_SEQ_MUL -- requirements
Module: booth_seq_mul

Interface
REQ-001 SHALL have parameter N, default 5: operand width in bits, N >= 2.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1: request to begin a multiply; sampled only in IDLE.
REQ-005 SHALL have port multiplicand, input, N: signed two's-complement M.
REQ-006 SHALL have port multiplier, input, N: signed two's-complement Q.
REQ-007 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-008 SHALL have port done, output, 1: single-cycle pulse, high only in DONE.
REQ-009 SHALL have port product, output, 2N: signed result M*Q, registered.

Function
REQ-010 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start=1; RUN->DONE after N iterations; DONE->IDLE unconditionally next cycle.
REQ-011 SHALL, on the accepting edge in IDLE, load: accumulator A=0 (N+1 bits), Q register=multiplier, q_1=0, M register=sign-extended multiplicand (N+1 bits), iteration counter=0.
REQ-012 SHALL, each RUN cycle, examine {Q[0],q_1}: 01 -> A=A+M; 10 -> A=A-M; 00/11 -> A unchanged; then arithmetic-shift {A,Q,q_1} right by one, all in the same cycle.
REQ-013 SHALL form A-M as A + ~M with carry-in 1 through the adder sub-module; no separate subtractor.
REQ-014 SHALL increment the counter each RUN cycle; exit RUN on the edge where counter reaches N-1.
REQ-015 SHALL, on the RUN->DONE edge, load product = {A[N-1:0],Q} after the final shift.
REQ-016 SHALL therefore give done exactly N+1 cycles after the start-accepting edge; busy high for N+1 cycles.
REQ-017 SHALL hold product stable from DONE until the next DONE; a new start does not clear it.
REQ-018 SHALL ignore start while busy=1; no queuing, no effect on the running operation.
REQ-019 SHALL accept start in the cycle directly after DONE (IDLE), allowing back-to-back operation every N+2 cycles.
REQ-020 SHALL latch operands only at acceptance; input changes during RUN do not affect the result.
REQ-021 SHALL produce the exact result for all operand pairs, including M=Q=-2^(N-1); the N+1-bit accumulator prevents overflow on -M.

Reset
REQ-022 SHALL, when rst=1 at a rising edge, force state=IDLE, busy=0, done=0, product=0, A=0, Q=0, q_1=0, counter=0.
REQ-023 SHALL give rst priority over start and abort any operation in progress with no done pulse.
REQ-024 SHALL accept start on the first edge after rst deasserts.

Structure
REQ-025 SHALL place the FSM state encoding (IDLE, RUN, DONE) and Booth op codes (NOP, ADD, SUB) in a shared multiplier package.
REQ-026 SHALL instantiate exactly one NBitAdder sub-module with width N+1; its carry-out SHALL be left unused.
REQ-027 SHALL size the counter to ceil(log2(N)) bits, with a minimum of 1.

Verification (N=5)
REQ-028 SHALL verify M=3, Q=-2 -> done 6 cycles after start, product=10'h3FA (-6).
REQ-029 SHALL verify M=-16, Q=-16 -> product=10'h100 (256).
REQ-030 SHALL verify M=15, Q=15 -> product=10'h0E1; then M=0, Q=-7 started the cycle after done -> product=0 and done 6 cycles later.
REQ-031 SHALL verify M=-16, Q=7 -> product=10'h390 (-112).
REQ-032 SHALL verify start pulsed again with new operands mid-RUN -> it is ignored, the original result appears, and there is exactly one done.
REQ-033 SHALL verify rst asserted in the 3rd RUN cycle -> busy=0, done=0, and product=0 on the next cycle, with no done afterward.
